// File: rtl/fetch_align_queue_pkg.sv
// Shared types for the RV32IC fetch realign queue.
package fetch_align_queue_pkg;

    typedef enum logic {
        ALIGN  = 1'b0,
        STREAM = 1'b1
    } align_state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        is_compressed;
    } fetch_pkt_t;

    function automatic logic is_rvc(input logic [15:0] hw);
        return hw[1:0] != 2'b11;
    endfunction

endpackage

// File: rtl/fetch_align_queue_hw_queue.sv
// Circular halfword buffer: pushes and pops 0..2 halfwords per cycle and
// exposes the two oldest entries.
module fetch_align_queue_hw_queue #(
    parameter int DEPTH_HW = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        clear,
    input  logic [1:0]                  push_cnt,
    input  logic [15:0]                 wdata0,
    input  logic [15:0]                 wdata1,
    input  logic [1:0]                  pop_cnt,
    output logic [15:0]                 hw0,
    output logic [15:0]                 hw1,
    output logic [$clog2(DEPTH_HW):0]   count
);
    localparam int PW = $clog2(DEPTH_HW);
    localparam int CW = PW + 1;

    logic [15:0]   mem [DEPTH_HW];
    logic [PW-1:0] rd_ptr, wr_ptr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + PW'(push_cnt);
            rd_ptr <= rd_ptr + PW'(pop_cnt);
            count  <= count + CW'(push_cnt) - CW'(pop_cnt);
        end
    end

    // Storage carries no reset; occupancy is tracked by the pointers alone.
    always_ff @(posedge clk) begin
        if (!clear) begin
            if (push_cnt != 2'd0) mem[wr_ptr]          <= wdata0;
            if (push_cnt == 2'd2) mem[wr_ptr + PW'(1)] <= wdata1;
        end
    end

    assign hw0 = mem[rd_ptr];
    assign hw1 = mem[rd_ptr + PW'(1)];

endmodule

// File: rtl/fetch_align_queue.sv
// RV32IC prefetch/realign queue: word fetches in, whole 16/32-bit
// instructions out, with redirect flush and stale-response dropping.
module fetch_align_queue
    import fetch_align_queue_pkg::*;
#(
    parameter int          DEPTH_HW        = 8,
    parameter int          MAX_OUTSTANDING = 2,
    parameter logic [31:0] RESET_PC        = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    output logic        mem_req_valid,
    output logic [31:0] mem_req_addr,
    input  logic        mem_req_ready,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic        out_is_compressed
);
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int CW = $clog2(DEPTH_HW) + 1;

    align_state_t  state;
    logic [31:0]   fetch_pc, pc_q;
    logic [OW-1:0] outstanding, drop_cnt, outstanding_nxt;
    logic [CW-1:0] count;
    logic [15:0]   hw0, hw1;
    logic          req_fire, resp_keep, out_fire, head_rvc, align_odd;
    logic [1:0]    push_cnt, pop_cnt;
    fetch_pkt_t    pkt;

    // Each in-flight request reserves a full word of queue space, so a
    // returning response always fits.
    always_comb begin
        mem_req_valid = !reset && !redirect_valid
                     && (32'(outstanding) < 32'(MAX_OUTSTANDING))
                     && ((32'(DEPTH_HW) - 32'(count)) >= ((32'(outstanding) + 32'd1) << 1));
        req_fire      = mem_req_valid && mem_req_ready;
        resp_keep     = mem_resp_valid && (drop_cnt == '0) && !redirect_valid;
        align_odd     = (state == ALIGN) && pc_q[1];
        push_cnt      = !resp_keep ? 2'd0 : (align_odd ? 2'd1 : 2'd2);
        head_rvc      = is_rvc(hw0);
        out_valid     = !redirect_valid && (head_rvc ? (count != '0) : (count >= CW'(2)));
        out_fire      = out_valid && out_ready;
        pop_cnt       = !out_fire ? 2'd0 : (head_rvc ? 2'd1 : 2'd2);
        outstanding_nxt = outstanding + OW'(req_fire) - OW'(mem_resp_valid);
        pkt.instr         = head_rvc ? {16'h0, hw0} : {hw1, hw0};
        pkt.pc            = pc_q;
        pkt.is_compressed = head_rvc;
    end

    fetch_align_queue_hw_queue #(.DEPTH_HW(DEPTH_HW)) u_queue (
        .clk      (clk),
        .reset    (reset),
        .clear    (redirect_valid),
        .push_cnt (push_cnt),
        .wdata0   (align_odd ? mem_resp_data[31:16] : mem_resp_data[15:0]),
        .wdata1   (mem_resp_data[31:16]),
        .pop_cnt  (pop_cnt),
        .hw0      (hw0),
        .hw1      (hw1),
        .count    (count)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ALIGN;
            fetch_pc    <= {RESET_PC[31:2], 2'b00};
            pc_q        <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            outstanding <= outstanding_nxt;
            if (redirect_valid) begin
                // Everything still in flight after this cycle is stale.
                state    <= ALIGN;
                pc_q     <= redirect_pc;
                fetch_pc <= {redirect_pc[31:2], 2'b00};
                drop_cnt <= outstanding_nxt;
            end else begin
                if (req_fire) fetch_pc <= fetch_pc + 32'd4;
                if (mem_resp_valid && drop_cnt != '0) drop_cnt <= drop_cnt - OW'(1);
                if (resp_keep) state <= STREAM;
                if (out_fire) pc_q <= pc_q + (head_rvc ? 32'd2 : 32'd4);
            end
        end
    end

    assign mem_req_addr      = fetch_pc;
    assign out_instr         = pkt.instr;
    assign out_pc            = pkt.pc;
    assign out_is_compressed = pkt.is_compressed;

endmodule

// File: tb/tb_fetch_align_queue.sv
// Scoreboard bench for fetch_align_queue with a fixed-latency memory model.
module tb_fetch_align_queue;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mem_req_valid, mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid, out_ready, out_is_compressed;
    logic [31:0] out_instr, out_pc;

    always #5 clk = ~clk;

    fetch_align_queue dut (
        .clk               (clk),
        .reset             (reset),
        .mem_req_valid     (mem_req_valid),
        .mem_req_addr      (mem_req_addr),
        .mem_req_ready     (mem_req_ready),
        .mem_resp_valid    (mem_resp_valid),
        .mem_resp_data     (mem_resp_data),
        .redirect_valid    (redirect_valid),
        .redirect_pc       (redirect_pc),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_instr         (out_instr),
        .out_pc            (out_pc),
        .out_is_compressed (out_is_compressed)
    );

    typedef struct { logic [31:0] instr; logic [31:0] pc; logic comp; } exp_t;
    typedef struct { int unsigned due; logic [31:0] addr; } mreq_t;

    exp_t        exp_q[$];
    mreq_t       pend[$];
    logic [31:0] rom [logic [31:0]];
    int          tests = 0, fails = 0;
    int unsigned cyc = 0, lat = 1, req_cnt = 0, pops = 0, last_pop = 0;
    logic        rdy_en = 1'b1;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        if (rom.exists(a)) return rom[a];
        return {a[23:0], 8'h33};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expect_pkt(input logic [31:0] instr, input logic [31:0] pc, input logic comp);
        exp_t e;
        e.instr = instr; e.pc = pc; e.comp = comp;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        out_ready = rdy_en && exp_q.size() != 0;
    endtask

    task automatic redirect(input logic [31:0] pc);
        tick();
        redirect_valid = 1'b1;
        redirect_pc = pc;
    endtask

    task automatic drain(input string name, input int maxc);
        int n = 0;
        while (exp_q.size() != 0 && n < maxc) begin
            tick();
            n++;
        end
        if (exp_q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL %s_timeout: %0d outputs still pending, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Memory: responds in order, lat cycles after acceptance.
    always @(posedge clk) begin
        #1;
        if (reset) begin
            pend.delete();
            mem_resp_valid = 1'b0;
        end else if (pend.size() != 0 && pend[0].due <= cyc) begin
            mem_resp_valid = 1'b1;
            mem_resp_data  = word_at(pend[0].addr);
            void'(pend.pop_front());
        end else begin
            mem_resp_valid = 1'b0;
        end
    end

    // Monitor: handshakes are observed on the falling edge.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && mem_req_valid && mem_req_ready) begin
            pend.push_back('{cyc + lat, mem_req_addr});
            req_cnt++;
            check("req_addr_align", {30'b0, mem_req_addr[1:0]}, 32'h0);
        end
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_out: got %h @%h, required no output", out_instr, out_pc);
            end else begin
                e = exp_q.pop_front();
                check("out_instr", out_instr, e.instr);
                check("out_pc", out_pc, e.pc);
                check("out_is_compressed", {31'b0, out_is_compressed}, {31'b0, e.comp});
                pops++;
                last_pop = cyc;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned c0, q0;
        int n;
        mem_req_ready  = 1'b1;
        mem_resp_valid = 1'b0;
        mem_resp_data  = 32'h0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        out_ready      = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_mem_req_valid", {31'b0, mem_req_valid}, 32'h0);
        check("reset_out_valid", {31'b0, out_valid}, 32'h0);
        check("reset_out_pc", out_pc, 32'h0);

        // 1: sequential 32-bit words, one instruction per cycle once primed
        for (int i = 0; i < 6; i++) expect_pkt({8'h0, 16'(i * 4), 8'h33}, 32'(i * 4), 1'b0);
        tick();
        reset = 1'b0;
        n = 0;
        while (pops == 0 && n < 50) begin tick(); n++; end
        c0 = last_pop;
        drain("t1", 50);
        check("t1_one_per_cycle", last_pop - c0, 32'd5);

        // 2: two halfwords in one word, second is a 32-bit straddler
        rom[32'h200] = 32'h0013_0001;
        rom[32'h204] = 32'h4505_0002;
        redirect(32'h200);
        expect_pkt(32'h0000_0001, 32'h200, 1'b1);
        expect_pkt(32'h0002_0013, 32'h202, 1'b0);
        expect_pkt(32'h0000_4505, 32'h206, 1'b1);
        drain("t2", 60);

        // 3: compressed, straddling 32-bit, 32-bit straddling again, compressed
        rom[32'h300] = 32'h0093_4501;
        rom[32'h304] = 32'h0513_0002;
        rom[32'h308] = 32'h0001_0001;
        redirect(32'h300);
        expect_pkt(32'h0000_4501, 32'h300, 1'b1);
        expect_pkt(32'h0002_0093, 32'h302, 1'b0);
        expect_pkt(32'h0001_0513, 32'h306, 1'b0);
        expect_pkt(32'h0000_0001, 32'h30A, 1'b1);
        drain("t3", 60);

        // 4: redirect to odd halfword with two stale requests in flight
        repeat (10) tick();
        lat = 3;
        rom[32'h100] = 32'h1234_5678;
        redirect(32'h400);
        q0 = req_cnt;
        tick();
        tick();
        redirect(32'h102);
        check("t4_outstanding_at_redirect", req_cnt - q0, 32'd2);
        expect_pkt(32'h0000_1234, 32'h102, 1'b1);
        expect_pkt(32'h0001_0433, 32'h104, 1'b0);
        drain("t4", 80);
        lat = 1;

        // 5: decode stalls, fetch backs off on credit, nothing is lost
        repeat (10) tick();
        redirect(32'h500);
        rdy_en = 1'b0;
        for (int i = 0; i < 8; i++) expect_pkt({8'h0, 16'(32'h500 + i * 4), 8'h33}, 32'h500 + 32'(i * 4), 1'b0);
        for (int i = 0; i < 10; i++) begin
            tick();
            if (i >= 3) begin
                check("t5_stall_out_valid", {31'b0, out_valid}, 32'h1);
                check("t5_stall_instr", out_instr, 32'h0005_0033);
                check("t5_stall_pc", out_pc, 32'h500);
            end
            if (i >= 6) check("t5_req_backoff", {31'b0, mem_req_valid}, 32'h0);
        end
        rdy_en = 1'b1;
        drain("t5", 60);

        // 6: redirect coincides with a response and a ready consumer
        repeat (10) tick();
        rom[32'h700] = 32'h0009_1111;
        redirect(32'h600);
        expect_pkt(32'h0006_0033, 32'h600, 1'b0);
        expect_pkt(32'h0006_0433, 32'h604, 1'b0);
        repeat (4) tick();
        redirect(32'h702);
        out_ready = 1'b1;
        #1;
        check("t6_no_valid_on_redirect", {31'b0, out_valid}, 32'h0);
        expect_pkt(32'h0000_0009, 32'h702, 1'b1);
        expect_pkt(32'h0007_0433, 32'h704, 1'b0);
        tick();
        check("t6_out_pc_after_redirect", out_pc, 32'h702);
        drain("t6", 60);

        repeat (3) tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
